apb_master: RTL and testbench



---
 rtl/apb_pkg.sv | 7 +
 rtl/apb_master.sv | 83 ++++++++
 tb/tb_apb_master.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: FSM state encodings shared between the APB requester and slave side
package apb_pkg;
  typedef logic [1:0] apb_state_t;
  localparam apb_state_t IDLE   = 2'b00;
  localparam apb_state_t SETUP  = 2'b01;
  localparam apb_state_t ACCESS = 2'b10;
endpackage

// File: rtl/apb_master.sv
// apb_master: valid/ready command channel to APB3 SETUP/ACCESS transfers with wait-state timeout
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  localparam bit TO_EN = TIMEOUT != 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  apb_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic accept, done, timeout;
  assign cmd_ready = state == IDLE;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = state == ACCESS && pready;
  // pready has priority: timeout only fires on a low pready sample
  assign timeout   = TO_EN && state == ACCESS && !pready && cnt == TO_LAST;
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state     <= IDLE;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end
  always_comb begin
    state_d = state == IDLE   ? (accept ? SETUP : IDLE) :
              state == SETUP  ? ACCESS :
              state == ACCESS ? ((done || timeout) ? IDLE : ACCESS) : IDLE;
  end
  always_comb begin
    psel_d      = state_d != IDLE;
    penable_d   = state_d == ACCESS;
    pwrite_d    = accept ? cmd_write : pwrite;
    paddr_d     = accept ? cmd_addr : paddr;
    pwdata_d    = accept ? cmd_wdata : pwdata;
    cnt_d       = accept ? '0 :
                  (state == ACCESS && !pready && cnt != '1) ? cnt + 1'b1 : cnt;
    rsp_valid_d = done || timeout;
    rsp_err_d   = timeout;
    rsp_rdata_d = (done && !pwrite) ? prdata : '0;
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: vector table plus scoreboard for the APB requester, with latency/back-to-back/reset sequences
module tb_apb_master;
  localparam int TO = 4;
  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_len;
  } vec_t;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          len;
  } exp_t;
  logic pclk = 1'b0, prst = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, pready = 1'b0;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata = '0;
  int tests = 0, fails = 0, cyc = 0;
  int cur_waits = 0, acc_n = 0, last_len = 0, rsp_n = 0;
  logic [31:0] cur_prdata = '0, cur_addr = '0, cur_wdata = '0;
  logic cur_w = 1'b0;
  exp_t q[$];
  int rsp_cyc[$];
  vec_t vecs[8];

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .pclk(pclk), .prst(prst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // slave model and response scoreboard
  always @(negedge pclk) begin
    if (psel && penable) acc_n++;
    else begin
      if (acc_n != 0) last_len = acc_n;
      acc_n = 0;
    end
    pready = psel && (penable ? (acc_n > cur_waits) : (cur_waits == 0));
    prdata = cur_prdata;
    if (psel) begin
      chk("paddr", paddr, cur_addr);
      chk("pwrite", pwrite, cur_w);
      if (cur_w) chk("pwdata", pwdata, cur_wdata);
    end
    if (rsp_valid) begin
      rsp_n++;
      rsp_cyc.push_back(cyc);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("access_len", last_len, e.len);
      end
    end
  end

  task automatic send(input vec_t v);
    int n;
    @(negedge pclk);
    cur_waits = v.waits;
    cur_prdata = v.prdata;
    cur_addr = v.addr;
    cur_wdata = v.wdata;
    cur_w = v.w;
    cmd_valid = 1'b1;
    cmd_write = v.w;
    cmd_addr = v.addr;
    cmd_wdata = v.wdata;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (n == 50) chk("accept_timeout", 0, 1);
    q.push_back('{err: v.exp_err, rdata: v.exp_rdata, len: v.exp_len});
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge pclk);
      #1 ok = q.size() == 0 && cmd_ready;
    end
    chk("drain", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, low, base;
    vecs[0] = '{1'b1, 32'h4,  32'hDEAD_BEEF, 32'h0,         0,   1'b0, 32'h0,         1};
    vecs[1] = '{1'b0, 32'h8,  32'h0,         32'h1234_5678, 2,   1'b0, 32'h1234_5678, 3};
    vecs[2] = '{1'b0, 32'hC,  32'h0,         32'hAAAA_5555, 0,   1'b0, 32'hAAAA_5555, 1};
    vecs[3] = '{1'b1, 32'h10, 32'h0102_0304, 32'hFFFF_0000, 1,   1'b0, 32'h0,         2};
    vecs[4] = '{1'b0, 32'h14, 32'h0,         32'h0BAD_F00D, 3,   1'b0, 32'h0BAD_F00D, 4};
    vecs[5] = '{1'b0, 32'h18, 32'h0,         32'hFFFF_FFFF, 255, 1'b1, 32'h0,         4};
    vecs[6] = '{1'b1, 32'h1C, 32'hCAFE_F00D, 32'h0,         4,   1'b1, 32'h0,         4};
    vecs[7] = '{1'b0, 32'h20, 32'h0,         32'h0000_0001, 4,   1'b1, 32'h0,         4};
    repeat (2) @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    prst = 1'b1;
    // zero-wait write: SETUP at N+1, ACCESS at N+2, response at N+3
    send(vecs[0]);
    @(negedge pclk);
    chk("lat_setup", {psel, penable, cmd_ready}, 3'b100);
    chk("lat_setup_pwdata", pwdata, 32'hDEAD_BEEF);
    @(negedge pclk);
    chk("lat_access", {psel, penable, rsp_valid}, 3'b110);
    chk("lat_access_pwdata", pwdata, 32'hDEAD_BEEF);
    @(negedge pclk);
    chk("lat_rsp", {rsp_valid, rsp_err, psel, cmd_ready}, 4'b1001);
    chk("lat_rsp_rdata", rsp_rdata, 0);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      send(vecs[i]);
      wait_idle();
    end
    // back-to-back: cmd_valid held high across three commands
    @(negedge pclk);
    cur_waits = 0;
    cur_prdata = 32'h5A5A_5A5A;
    cur_addr = 32'h40;
    cur_w = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 32'h40;
    #1 cmd_valid = 1'b1;
    acc = 0;
    low = 0;
    base = rsp_n;
    rsp_cyc.delete();
    for (int g = 0; g < 60 && (acc < 3 || rsp_n - base < 3); g++) begin
      if (acc >= 1 && rsp_n - base < 3 && !psel) low++;
      if (cmd_valid && cmd_ready) begin
        q.push_back('{err: 1'b0, rdata: 32'h5A5A_5A5A, len: 1});
        acc++;
      end
      @(posedge pclk);
      #1 if (acc == 3) cmd_valid = 1'b0;
      @(negedge pclk);
      #1;
    end
    chk("b2b_rsp_count", rsp_cyc.size(), 3);
    if (rsp_cyc.size() == 3) begin
      chk("b2b_gap1", rsp_cyc[1] - rsp_cyc[0], 3);
      chk("b2b_gap2", rsp_cyc[2] - rsp_cyc[1], 3);
    end
    chk("b2b_psel_low", low, 2);
    wait_idle();
    // asynchronous reset in the middle of ACCESS
    send('{1'b0, 32'h60, 32'h0, 32'h7777_7777, 255, 1'b1, 32'h0, 4});
    repeat (3) @(negedge pclk);
    chk("pre_rst_penable", penable, 1);
    #2 prst = 1'b0;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    q.delete();
    repeat (2) @(negedge pclk);
    prst = 1'b1;
    repeat (3) @(negedge pclk);
    send('{1'b1, 32'h64, 32'h1357_9BDF, 32'h0, 1, 1'b0, 32'h0, 2});
    wait_idle();
    repeat (3) @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
